// File: rtl/hyperbus_burst_ctrl.sv
// HyperBus leader controller: burst commands in, CA/latency/data sequencing out
// to a 2-beat-per-clock DDR PHY, with tCSM segment splitting and read timeout.
module hyperbus_burst_ctrl #(
    parameter int WIDTH         = 8,
    parameter int ADDR_LENGTH   = 32,
    parameter int LEN_WIDTH     = 10,
    parameter int TACC_COUNT    = 6,
    parameter int FIXED_LATENCY = 0,
    parameter int MAX_BEATS     = 64,
    parameter int RECOVER_COUNT = 3,
    parameter int RESET_COUNT   = 5,
    parameter int TIMEOUT_COUNT = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic                   cmd_reg,
    input  logic [ADDR_LENGTH-1:0] cmd_adr,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic [2*WIDTH-1:0]     wr_data,
    input  logic [WIDTH/4-1:0]     wr_mask,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [2*WIDTH-1:0]     rd_data,
    output logic                   rd_valid,
    output logic                   done,
    output logic                   err,
    output logic                   phy_ck_en,
    output logic                   phy_csn,
    output logic                   phy_rstn,
    output logic [2*WIDTH-1:0]     phy_dq_o,
    output logic                   phy_dq_oe,
    output logic [WIDTH/4-1:0]     phy_rwds_o,
    output logic                   phy_rwds_oe,
    input  logic [2*WIDTH-1:0]     phy_dq_i,
    input  logic [WIDTH/4-1:0]     phy_rwds_i
);
    localparam int MW    = WIDTH / 4;
    localparam int DW    = 2 * WIDTH;
    localparam int CW    = LEN_WIDTH + 1;
    localparam int CNT_W = 16;
    localparam logic [CW-1:0] MAX_B = CW'(MAX_BEATS);

    typedef enum logic [2:0] {
        ST_RESET, ST_IDLE, ST_CA, ST_LATENCY, ST_WRITE, ST_READ, ST_RECOVER
    } state_t;

    state_t                   state_reg;
    logic                     rw_reg;
    logic                     reg_space_reg;
    logic                     dbl_reg;
    logic                     err_flag_reg;
    logic [ADDR_LENGTH-1:0]   cur_adr_reg;
    logic [CW-1:0]            remaining_reg;
    logic [CW-1:0]            beat_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [DW-1:0]            rd_data_reg;
    logic                     rd_valid_reg;
    logic                     done_reg;
    logic                     err_reg;

    logic [CW-1:0]            seg;
    logic                     seg_last;
    logic                     strobe;
    logic [CNT_W-1:0]         lat_len;
    logic                     lat_last;
    logic [47:0]              ca_word;
    logic [15:0]              ca_part;
    logic [MW-1:0]            strobe_pat;

    // A valid read beat shows RWDS high on the first DDR edge, low on the second.
    for (genvar gi = 0; gi < MW; gi++) begin : g_strobe_pat
        assign strobe_pat[gi] = ((gi % 2) == 1);
    end

    assign strobe   = (phy_rwds_i == strobe_pat);
    assign seg      = (remaining_reg > MAX_B) ? MAX_B : remaining_reg;
    assign seg_last = ((beat_reg + CW'(1)) == seg);
    assign lat_len  = dbl_reg ? CNT_W'(2 * TACC_COUNT - 2) : CNT_W'(TACC_COUNT - 2);
    assign lat_last = (cnt_reg == (lat_len - CNT_W'(1)));

    always_comb begin
        ca_word        = '0;
        ca_word[47]    = rw_reg;
        ca_word[46]    = reg_space_reg;
        ca_word[45]    = 1'b1;
        ca_word[44:16] = 29'(cur_adr_reg >> 3);
        ca_word[2:0]   = cur_adr_reg[2:0];
    end

    always_comb begin
        case (cnt_reg[1:0])
            2'd0:    ca_part = ca_word[47:32];
            2'd1:    ca_part = ca_word[31:16];
            default: ca_part = ca_word[15:0];
        endcase
    end

    always_ff @(posedge clk) begin
        rd_valid_reg <= 1'b0;
        done_reg     <= 1'b0;
        err_reg      <= 1'b0;
        if (rst) begin
            state_reg     <= ST_RESET;
            cnt_reg       <= '0;
            beat_reg      <= '0;
            remaining_reg <= '0;
            err_flag_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_RESET: begin
                    if (cnt_reg == CNT_W'(RESET_COUNT)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid) begin
                        rw_reg        <= cmd_rw;
                        reg_space_reg <= cmd_reg;
                        cur_adr_reg   <= cmd_adr;
                        remaining_reg <= CW'(cmd_len) + CW'(1);
                        beat_reg      <= '0;
                        cnt_reg       <= '0;
                        err_flag_reg  <= 1'b0;
                        state_reg     <= ST_CA;
                    end
                end
                ST_CA: begin
                    if (cnt_reg == '0) begin
                        dbl_reg <= (FIXED_LATENCY != 0) || (|phy_rwds_i);
                    end
                    if (cnt_reg == CNT_W'(2)) begin
                        cnt_reg <= '0;
                        if (!rw_reg && reg_space_reg) begin
                            state_reg <= ST_WRITE;
                        end else begin
                            state_reg <= ST_LATENCY;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_LATENCY: begin
                    if (lat_last) begin
                        cnt_reg <= '0;
                        if (rw_reg) begin
                            state_reg <= ST_READ;
                        end else begin
                            state_reg <= ST_WRITE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    // A stalled beat leaves CS# low and simply waits for data.
                    if (wr_valid) begin
                        if (seg_last) begin
                            remaining_reg <= remaining_reg - seg;
                            cur_adr_reg   <= cur_adr_reg + ADDR_LENGTH'(seg);
                            beat_reg      <= '0;
                            cnt_reg       <= '0;
                            state_reg     <= ST_RECOVER;
                        end else begin
                            beat_reg <= beat_reg + CW'(1);
                        end
                    end
                end
                ST_READ: begin
                    if (strobe) begin
                        rd_data_reg  <= phy_dq_i;
                        rd_valid_reg <= 1'b1;
                        cnt_reg      <= '0;
                        if (seg_last) begin
                            remaining_reg <= remaining_reg - seg;
                            cur_adr_reg   <= cur_adr_reg + ADDR_LENGTH'(seg);
                            beat_reg      <= '0;
                            state_reg     <= ST_RECOVER;
                        end else begin
                            beat_reg <= beat_reg + CW'(1);
                        end
                    end else if (cnt_reg == CNT_W'(TIMEOUT_COUNT - 1)) begin
                        err_flag_reg  <= 1'b1;
                        remaining_reg <= '0;
                        beat_reg      <= '0;
                        cnt_reg       <= '0;
                        state_reg     <= ST_RECOVER;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RECOVER: begin
                    if (cnt_reg == CNT_W'(RECOVER_COUNT - 1)) begin
                        cnt_reg <= '0;
                        if (remaining_reg != '0) begin
                            state_reg <= ST_CA;
                        end else begin
                            done_reg  <= 1'b1;
                            err_reg   <= err_flag_reg;
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= ST_RESET;
            endcase
        end
    end

    // Bus controls are decoded from the state register; the write path is
    // combinational so a missing word stops the HyperBus clock the same cycle.
    always_comb begin
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        phy_ck_en   = 1'b0;
        phy_csn     = 1'b1;
        phy_rstn    = 1'b1;
        phy_dq_o    = '0;
        phy_dq_oe   = 1'b0;
        phy_rwds_o  = '0;
        phy_rwds_oe = 1'b0;
        case (state_reg)
            ST_RESET: phy_rstn = 1'b0;
            ST_IDLE:  cmd_ready = 1'b1;
            ST_CA: begin
                phy_csn   = 1'b0;
                phy_ck_en = 1'b1;
                phy_dq_oe = 1'b1;
                phy_dq_o  = DW'(ca_part);
            end
            ST_LATENCY: begin
                phy_csn     = 1'b0;
                phy_ck_en   = 1'b1;
                phy_rwds_oe = !rw_reg && lat_last;
            end
            ST_WRITE: begin
                phy_csn     = 1'b0;
                phy_dq_oe   = 1'b1;
                phy_rwds_oe = 1'b1;
                wr_ready    = wr_valid;
                phy_ck_en   = wr_valid;
                phy_dq_o    = wr_data;
                phy_rwds_o  = wr_mask;
            end
            ST_READ: begin
                phy_csn   = 1'b0;
                phy_ck_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign done     = done_reg;
    assign err      = err_reg;

endmodule
